// File: rtl/mm_arb_pkg.sv
// mm_arb_pkg: shared types and constants for the CSR port arbiter
package mm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_ISSUE,
        RD_WAIT
    } state_t;

    localparam logic [31:0] TIMEOUT_TAG = 32'hDEAD_0000;
    localparam int          TIMER_W     = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grant
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic [IW-1:0] cand;

    // walk from lowest to highest priority so the nearest requester after last wins
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) idx = cand;
        end
    end

    assign vld = |req;
    assign gnt = vld ? N'(1) << idx : '0;

endmodule

// File: rtl/mm_csr_arbiter.sv
// mm_csr_arbiter: round-robin sharing of one MM CSR port with read timeout
module mm_csr_arbiter
    import mm_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_wr_en,
    input  logic [N_REQ-1:0]               req_rd_en,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_wr_data,
    output logic [N_REQ-1:0]               req_gnt,
    output logic [DATA_W-1:0]              rsp_rd_data,
    output logic [N_REQ-1:0]               rsp_rd_data_v,
    output logic                           oMM_WR_EN,
    output logic                           oMM_RD_EN,
    output logic [ADDR_W-1:0]              oMM_ADDR,
    output logic [DATA_W-1:0]              oMM_WR_DATA,
    input  logic [DATA_W-1:0]              iMM_RD_DATA,
    input  logic                           iMM_RD_DATA_V,
    output logic                           timeout_pulse,
    output logic [15:0]                    timeout_cnt
);

    localparam int IW = $clog2(N_REQ);

    state_t               state, state_n;
    logic [IW-1:0]        last_gnt, last_n;
    logic [IW-1:0]        owner, owner_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [N_REQ-1:0]     gnt_n, rv_n;
    logic                 wr_n, rd_n, tp_n;
    logic [ADDR_W-1:0]    addr_n;
    logic [DATA_W-1:0]    wdata_n, rdata_n;
    logic [15:0]          tc_n;
    logic [N_REQ-1:0]     pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req  (req_wr_en | req_rd_en),
        .last (last_gnt),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // next-state and next-output logic; everything lands in registers below
    always_comb begin
        state_n = state;
        last_n  = last_gnt;
        owner_n = owner;
        timer_n = timer;
        gnt_n   = '0;
        rv_n    = '0;
        wr_n    = 1'b0;
        rd_n    = 1'b0;
        tp_n    = 1'b0;
        addr_n  = oMM_ADDR;
        wdata_n = oMM_WR_DATA;
        rdata_n = rsp_rd_data;
        tc_n    = timeout_cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_n   = pick_gnt;
                    last_n  = pick_idx;
                    owner_n = pick_idx;
                    addr_n  = req_addr[pick_idx];
                    if (req_wr_en[pick_idx]) begin
                        wr_n    = 1'b1;
                        wdata_n = req_wr_data[pick_idx];
                        state_n = WR_ISSUE;
                    end else begin
                        rd_n    = 1'b1;
                        timer_n = '0;
                        state_n = RD_WAIT;
                    end
                end
            end
            WR_ISSUE: state_n = IDLE;
            RD_WAIT: begin
                timer_n = timer + TIMER_W'(1);
                if (iMM_RD_DATA_V) begin
                    rdata_n = iMM_RD_DATA;
                    rv_n    = N_REQ'(1) << owner;
                    state_n = IDLE;
                end else if (timer == TIMER_W'(TIMEOUT)) begin
                    rdata_n = DATA_W'({TIMEOUT_TAG, 32'(oMM_ADDR)});
                    rv_n    = N_REQ'(1) << owner;
                    tp_n    = 1'b1;
                    tc_n    = (timeout_cnt == 16'hFFFF) ? timeout_cnt : timeout_cnt + 16'd1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; reset drops any in-flight read silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_gnt      <= IW'(N_REQ - 1);
            owner         <= '0;
            timer         <= '0;
            req_gnt       <= '0;
            rsp_rd_data_v <= '0;
            rsp_rd_data   <= '0;
            oMM_WR_EN     <= 1'b0;
            oMM_RD_EN     <= 1'b0;
            oMM_ADDR      <= '0;
            oMM_WR_DATA   <= '0;
            timeout_pulse <= 1'b0;
            timeout_cnt   <= '0;
        end else begin
            state         <= state_n;
            last_gnt      <= last_n;
            owner         <= owner_n;
            timer         <= timer_n;
            req_gnt       <= gnt_n;
            rsp_rd_data_v <= rv_n;
            rsp_rd_data   <= rdata_n;
            oMM_WR_EN     <= wr_n;
            oMM_RD_EN     <= rd_n;
            oMM_ADDR      <= addr_n;
            oMM_WR_DATA   <= wdata_n;
            timeout_pulse <= tp_n;
            timeout_cnt   <= tc_n;
        end
    end

endmodule

// File: tb/tb_mm_csr_arbiter.sv
// tb_mm_csr_arbiter: scoreboard bench for grant order, strobes, read responses and timeouts
module tb_mm_csr_arbiter;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_wr_en, req_rd_en;
    logic [1:0][13:0]     req_addr;
    logic [1:0][63:0]     req_wr_data;
    logic [1:0]           req_gnt;
    logic [63:0]          rsp_rd_data;
    logic [1:0]           rsp_rd_data_v;
    logic                 oMM_WR_EN, oMM_RD_EN;
    logic [13:0]          oMM_ADDR;
    logic [63:0]          oMM_WR_DATA;
    logic [63:0]          iMM_RD_DATA;
    logic                 iMM_RD_DATA_V;
    logic                 timeout_pulse;
    logic [15:0]          timeout_cnt;

    mm_csr_arbiter #(.N_REQ(2), .ADDR_W(14), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_wr_en     (req_wr_en),
        .req_rd_en     (req_rd_en),
        .req_addr      (req_addr),
        .req_wr_data   (req_wr_data),
        .req_gnt       (req_gnt),
        .rsp_rd_data   (rsp_rd_data),
        .rsp_rd_data_v (rsp_rd_data_v),
        .oMM_WR_EN     (oMM_WR_EN),
        .oMM_RD_EN     (oMM_RD_EN),
        .oMM_ADDR      (oMM_ADDR),
        .oMM_WR_DATA   (oMM_WR_DATA),
        .iMM_RD_DATA   (iMM_RD_DATA),
        .iMM_RD_DATA_V (iMM_RD_DATA_V),
        .timeout_pulse (timeout_pulse),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic        wr;
        logic        rd;
        logic [13:0] addr;
        logic [63:0] data;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  v;
        logic [63:0] data;
        logic        tp;
        logic [15:0] tc;
    } rexp_t;

    gexp_t       gq[$];
    rexp_t       rq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          dec_due = -1;
    int          rd_delay = -1;
    logic [63:0] dec_data = '0;
    int          wr_left[2];
    int          c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_g(input int cy, input logic [1:0] g, input logic w, input logic r,
                          input logic [13:0] a, input logic [63:0] d);
        gexp_t e;
        e.cyc = cy; e.gnt = g; e.wr = w; e.rd = r; e.addr = a; e.data = d;
        gq.push_back(e);
    endtask

    task automatic push_r(input int cy, input logic [1:0] v, input logic [63:0] d,
                          input logic tp, input logic [15:0] tc);
        rexp_t e;
        e.cyc = cy; e.v = v; e.data = d; e.tp = tp; e.tc = tc;
        rq.push_back(e);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_gnt"},   64'(req_gnt), 64'd0);
        check({pfx, "_rspv"},  64'(rsp_rd_data_v), 64'd0);
        check({pfx, "_rdata"}, rsp_rd_data, 64'd0);
        check({pfx, "_wren"},  64'(oMM_WR_EN), 64'd0);
        check({pfx, "_rden"},  64'(oMM_RD_EN), 64'd0);
        check({pfx, "_addr"},  64'(oMM_ADDR), 64'd0);
        check({pfx, "_wdata"}, oMM_WR_DATA, 64'd0);
        check({pfx, "_tp"},    64'(timeout_pulse), 64'd0);
        check({pfx, "_tc"},    64'(timeout_cnt), 64'd0);
    endtask

    // one clock: sample outputs, score them, then play decoder and masters
    task automatic step();
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        cyc++;
        while (gq.size() > 0 && gq[0].cyc < cyc) begin
            check("gnt_missed", 64'(cyc), 64'(gq[0].cyc));
            void'(gq.pop_front());
        end
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            check("gnt_vec", 64'(req_gnt), 64'(g.gnt));
            check("wr_en", 64'(oMM_WR_EN), 64'(g.wr));
            check("rd_en", 64'(oMM_RD_EN), 64'(g.rd));
            check("mm_addr", 64'(oMM_ADDR), 64'(g.addr));
            if (g.wr) check("mm_wdata", oMM_WR_DATA, g.data);
        end else if (|{req_gnt, oMM_WR_EN, oMM_RD_EN}) begin
            check("spurious_gnt", 64'({req_gnt, oMM_WR_EN, oMM_RD_EN}), 64'd0);
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            check("rsp_missed", 64'(cyc), 64'(rq[0].cyc));
            void'(rq.pop_front());
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            check("rsp_v", 64'(rsp_rd_data_v), 64'(r.v));
            check("rsp_data", rsp_rd_data, r.data);
            check("to_pulse", 64'(timeout_pulse), 64'(r.tp));
            check("to_cnt", 64'(timeout_cnt), 64'(r.tc));
        end else if (|{rsp_rd_data_v, timeout_pulse}) begin
            check("spurious_rsp", 64'({rsp_rd_data_v, timeout_pulse}), 64'd0);
        end
        iMM_RD_DATA_V = (cyc == dec_due);
        iMM_RD_DATA   = iMM_RD_DATA_V ? dec_data : 64'd0;
        if (oMM_RD_EN && rd_delay > 0) dec_due = cyc + rd_delay;
        for (int i = 0; i < 2; i++) begin
            if (req_gnt[i]) begin
                if (req_wr_en[i]) begin
                    if (wr_left[i] > 0) begin
                        req_wr_data[i] = req_wr_data[i] + 64'd1;
                        wr_left[i]--;
                    end else begin
                        req_wr_en[i] = 1'b0;
                    end
                end else begin
                    req_rd_en[i] = 1'b0;
                end
            end
        end
    endtask

    // run until every expectation is scored (bounded), then one idle cycle
    task automatic drain();
        int n = 0;
        while ((gq.size() > 0 || rq.size() > 0) && n < 100) begin
            step();
            n++;
        end
        if (gq.size() > 0 || rq.size() > 0) begin
            check("drain_timeout", 64'(gq.size() + rq.size()), 64'd0);
            gq.delete();
            rq.delete();
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_wr_en = '0;
        req_rd_en = '0;
        req_addr = '0;
        req_wr_data = '0;
        iMM_RD_DATA = '0;
        iMM_RD_DATA_V = 1'b0;
        wr_left[0] = 0;
        wr_left[1] = 0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // single write from master 0
        c = cyc;
        req_addr[0] = 14'h0010; req_wr_data[0] = 64'h1234; req_wr_en[0] = 1'b1;
        push_g(c + 1, 2'b01, 1'b1, 1'b0, 14'h0010, 64'h1234);
        drain();

        // continuous writes from both; pointer sits on 0 so master 1 leads
        c = cyc;
        req_addr[0] = 14'h0020; req_wr_data[0] = 64'hA0; wr_left[0] = 1; req_wr_en[0] = 1'b1;
        req_addr[1] = 14'h0030; req_wr_data[1] = 64'hB0; wr_left[1] = 1; req_wr_en[1] = 1'b1;
        push_g(c + 1, 2'b10, 1'b1, 1'b0, 14'h0030, 64'hB0);
        push_g(c + 3, 2'b01, 1'b1, 1'b0, 14'h0020, 64'hA0);
        push_g(c + 5, 2'b10, 1'b1, 1'b0, 14'h0030, 64'hB1);
        push_g(c + 7, 2'b01, 1'b1, 1'b0, 14'h0020, 64'hA1);
        drain();

        // master 1 read, decoder answers two cycles after the strobe
        rd_delay = 2; dec_data = 64'hCAFE;
        c = cyc;
        req_addr[1] = 14'h0400; req_rd_en[1] = 1'b1;
        push_g(c + 1, 2'b10, 1'b0, 1'b1, 14'h0400, 64'd0);
        push_r(c + 4, 2'b10, 64'hCAFE, 1'b0, 16'd0);
        drain();

        // master 0 read with no decoder response -> tagged timeout
        rd_delay = -1;
        c = cyc;
        req_addr[0] = 14'h0155; req_rd_en[0] = 1'b1;
        push_g(c + 1, 2'b01, 1'b0, 1'b1, 14'h0155, 64'd0);
        push_r(c + 10, 2'b01, 64'hDEAD_0000_0000_0155, 1'b1, 16'd1);
        drain();

        // a late valid while idle must be ignored
        dec_due = cyc + 1; dec_data = 64'h5555;
        step();
        step();
        check("stray_rsp_v", 64'(rsp_rd_data_v), 64'd0);
        check("stray_tc", 64'(timeout_cnt), 64'd1);
        step();

        // valid lands on the timeout cycle: data wins, no timeout counted
        rd_delay = 8; dec_data = 64'hBEEF_0001;
        c = cyc;
        req_addr[1] = 14'h0200; req_rd_en[1] = 1'b1;
        push_g(c + 1, 2'b10, 1'b0, 1'b1, 14'h0200, 64'd0);
        push_r(c + 10, 2'b10, 64'hBEEF_0001, 1'b0, 16'd1);
        drain();

        // write and read together on master 0: write first, read after
        rd_delay = 2; dec_data = 64'h0123_4567_89AB_CDEF;
        c = cyc;
        req_addr[0] = 14'h3FFF; req_wr_data[0] = 64'h77; wr_left[0] = 0;
        req_wr_en[0] = 1'b1; req_rd_en[0] = 1'b1;
        push_g(c + 1, 2'b01, 1'b1, 1'b0, 14'h3FFF, 64'h77);
        push_g(c + 3, 2'b01, 1'b0, 1'b1, 14'h3FFF, 64'd0);
        push_r(c + 6, 2'b01, 64'h0123_4567_89AB_CDEF, 1'b0, 16'd1);
        drain();

        // reset in the middle of a read, then master retries
        rd_delay = -1;
        c = cyc;
        req_addr[1] = 14'h00AB; req_rd_en[1] = 1'b1;
        push_g(c + 1, 2'b10, 1'b0, 1'b1, 14'h00AB, 64'd0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check_zero("midrd_rst");
        rst = 1'b0;
        rd_delay = 2; dec_data = 64'hFACE; dec_due = -1;
        req_addr[0] = 14'h0011; req_wr_data[0] = 64'h99; wr_left[0] = 0; req_wr_en[0] = 1'b1;
        req_rd_en[1] = 1'b1;
        push_g(c + 5, 2'b01, 1'b1, 1'b0, 14'h0011, 64'h99);
        push_g(c + 7, 2'b10, 1'b0, 1'b1, 14'h00AB, 64'd0);
        push_r(c + 10, 2'b10, 64'hFACE, 1'b0, 16'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
